matmul_2x2_top: RTL and testbench
=================================

// Module: matmul_2x2_top
// PURPOSE
//   Sequential signed 2x2-by-2x2 matrix multiplier (generalised inner dimension K).
//   Latches A and B on start, runs four parallel MACs for K cycles, presents C = A x B, pulses done.
//   Compute core behind the AXI register/stream front-end; inputs/outputs are unpacked arrays.
// PARAMETERS
//   DATA_W  16  width of each signed A/B element
//   ACC_W   32  width of each signed C element / accumulator
//   K       2   inner dimension (A is 2xK, B is Kx2); legal range 1..16
// PORTS
//   clk    in   1                clock, all state on rising edge
//   rst    in   1                asynchronous, active-high reset
//   start  in   1                request; sampled only in IDLE
//   A      in   [DATA_W] [2][K]  signed left operand, A[row][k]
//   B      in   [DATA_W] [K][2]  signed right operand, B[k][col]
//   C      out  [ACC_W]  [2][2]  signed result, registered
//   done   out  1                one-cycle pulse, C valid and final
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, k=0, accumulators=0, C=0, done=0.
//   FSM states IDLE, MAC, DONE:
//   - IDLE: start=1 at an edge -> latch A,B into operand regs, clear acc, k=0, go MAC.
//     start=0 -> stay.
//   - MAC: each edge acc[i][j] += Areg[i][k]*Breg[k][j] for all i,j in parallel; k++.
//     On the edge processing k==K-1, write the final sums into C and go DONE.
//   - DONE: done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
//   Latency: start sampled at edge 0; C updated and done rises at edge K;
//     done falls at edge K+1. For K=2, done is high between edges 2 and 3.
//   A re-start is accepted no earlier than edge K+2. If start is held high, the
//     block restarts continuously, with a period of K+2 cycles.
//   start during MAC or DONE is ignored; no queuing.
//   A/B changes after the latch edge have no effect on the running job.
//   C holds its value from DONE until the next DONE or reset; it is not cleared by a new start.
//   Arithmetic: signed DATA_W x DATA_W -> 2*DATA_W product; sign-extend to ACC_W.
//     Accumulate modulo 2^ACC_W (two's-complement wrap) unless MATMUL_SAT_EN.
//   done is a registered output, glitch-free; there are no combinational paths from inputs to outputs.
//   Reset mid-operation aborts the job immediately: IDLE, C=0, done=0.
//     A start in the first cycle after reset release is accepted normally.
// CONFIGURATION
//   MATMUL_SAT_EN defined: each accumulate step saturates to
//     [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping; the clamp applies to C.
//   MATMUL_SAT_EN undefined: pure wrap-around; no saturation logic synthesised.
// TESTING
//   1) A={{1,2},{3,4}}, B={{5,6},{7,8}}, start=1 one cycle
//      -> done at edge 2, C={{19,22},{43,50}}, done low next cycle.
//   2) A={{-1,2},{3,-4}}, B={{5,-6},{7,8}} -> C={{9,22},{-13,-50}}.
//   3) All A,B elements = -32768 -> each C = -2147483648 (wrap);
//      with MATMUL_SAT_EN each C = 2147483647.
//   4) Start test 1, then change A,B to zeros at edge 1 -> C still {{19,22},{43,50}}.
//   5) Assert rst for one cycle between edges 1 and 2 of a job -> done never pulses, C=0;
//      after release, start with test 1 operands -> correct result.
//   6) Hold start=1 continuously -> done pulses at edges 2, 6, 10 ..., each with the correct C;
//      compare every pulse against a golden 2x2 model.

Source files
------------

// File: rtl/matmul_2x2_top_if.sv
// matmul_2x2_top_if: operand/result bundle for the 2x2 matrix multiplier core.
// master drives start/A/B and observes C/done; slave is the compute core side.
interface matmul_2x2_top_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int K      = 2
);
    logic                     start;
    logic signed [DATA_W-1:0] A [2][K];
    logic signed [DATA_W-1:0] B [K][2];
    logic signed [ACC_W-1:0]  C [2][2];
    logic                     done;

    modport master (
        output start,
        output A,
        output B,
        input  C,
        input  done
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output C,
        output done
    );
endinterface

// File: rtl/matmul_2x2_top.sv
// matmul_2x2_top: sequential signed 2x2 (x K) by (K x) 2 matrix multiplier.
// Latches A/B on start, runs four parallel MACs for K cycles, registers C and
// pulses done for one cycle. Optional macro MATMUL_SAT_EN makes every
// accumulate step saturate instead of wrapping.
module matmul_2x2_top #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int K      = 2
) (
    input  logic             clk,
    input  logic             rst,
    matmul_2x2_top_if.slave  bus
);
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t                   state;
    logic [KW-1:0]            k_cnt;
    logic signed [DATA_W-1:0] a_reg    [2][K];
    logic signed [DATA_W-1:0] b_reg    [K][2];
    logic signed [ACC_W-1:0]  acc      [2][2];
    logic signed [ACC_W-1:0]  acc_next [2][2];

    // Full-precision signed product, sign-extended into the accumulator width.
    function automatic logic signed [ACC_W-1:0] product_ext(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [PW-1:0] p;
        p = PW'(a) * PW'(b);
        return ACC_W'(p);
    endfunction

`ifdef MATMUL_SAT_EN
    // One accumulate step clamped to the signed ACC_W range.
    function automatic logic signed [ACC_W-1:0] acc_step(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] p
    );
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(p);
        if (s[ACC_W] != s[ACC_W-1]) begin
            if (s[ACC_W]) begin
                return {1'b1, {(ACC_W-1){1'b0}}};
            end
            return {1'b0, {(ACC_W-1){1'b1}}};
        end
        return s[ACC_W-1:0];
    endfunction
`else
    // One accumulate step, two's-complement wrap modulo 2^ACC_W.
    function automatic logic signed [ACC_W-1:0] acc_step(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] p
    );
        return a + p;
    endfunction
`endif

    // Next accumulator values for the current inner index k_cnt.
    always_comb begin
        acc_next = acc;
        for (int unsigned i = 0; i < 2; i++) begin
            for (int unsigned j = 0; j < 2; j++) begin
                acc_next[i][j] = acc_step(acc[i][j],
                                          product_ext(a_reg[i][k_cnt], b_reg[k_cnt][j]));
            end
        end
    end

    // Control FSM plus operand, accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k_cnt    <= '0;
            a_reg    <= '{default: '0};
            b_reg    <= '{default: '0};
            acc      <= '{default: '0};
            bus.C    <= '{default: '0};
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.A;
                        b_reg <= bus.B;
                        acc   <= '{default: '0};
                        k_cnt <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc   <= acc_next;
                    k_cnt <= k_cnt + KW'(1);
                    // The final step bypasses acc so C and done land on the same edge.
                    if (k_cnt == KW'(K - 1)) begin
                        bus.C    <= acc_next;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_2x2_top.sv
// tb_matmul_2x2_top: directed self-checking bench for matmul_2x2_top (K=2).
module tb_matmul_2x2_top;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int K      = 2;

    typedef logic signed [DATA_W-1:0] mat_ab_t [2][2];
    typedef logic signed [ACC_W-1:0]  mat_c_t  [2][2];

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    matmul_2x2_top_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .K(K)) bus ();

    matmul_2x2_top #(.DATA_W(DATA_W), .ACC_W(ACC_W), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    mat_ab_t a1, b1, a2, b2, a3, b3, a4, b4, zero_ab;
    mat_c_t  c1, c2, c3, c_zero, exp_c;
    mat_ab_t ops_a [3];
    mat_ab_t ops_b [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input mat_ab_t a, input mat_ab_t b);
        bus.A = a;
        bus.B = b;
    endtask

    task automatic check_done(input string tag, input logic exp);
        checks++;
        assert (bus.done === exp) else begin
            failures++;
            $error("FAIL %s done observed=%b expected=%b", tag, bus.done, exp);
        end
    endtask

    task automatic check_c(input string tag, input mat_c_t exp);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                checks++;
                assert (bus.C[i][j] === exp[i][j]) else begin
                    failures++;
                    $error("FAIL %s C[%0d][%0d] observed=%0d expected=%0d",
                           tag, i, j, bus.C[i][j], exp[i][j]);
                end
            end
        end
    endtask

    // Golden 2x2 product with 32-bit wrap.
    task automatic model(input mat_ab_t a, input mat_ab_t b, output mat_c_t c);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                c[i][j] = '0;
                for (int k = 0; k < K; k++) begin
                    c[i][j] = c[i][j] + ACC_W'(a[i][k]) * ACC_W'(b[k][j]);
                end
            end
        end
    endtask

    initial begin
        a1      = '{'{1, 2}, '{3, 4}};
        b1      = '{'{5, 6}, '{7, 8}};
        c1      = '{'{19, 22}, '{43, 50}};
        a2      = '{'{-1, 2}, '{3, -4}};
        b2      = '{'{5, -6}, '{7, 8}};
        c2      = '{'{9, 22}, '{-13, -50}};
        a3      = '{'{-32768, -32768}, '{-32768, -32768}};
        b3      = '{'{-32768, -32768}, '{-32768, -32768}};
`ifdef MATMUL_SAT_EN
        c3      = '{'{32'sh7fffffff, 32'sh7fffffff}, '{32'sh7fffffff, 32'sh7fffffff}};
`else
        c3      = '{'{32'sh80000000, 32'sh80000000}, '{32'sh80000000, 32'sh80000000}};
`endif
        a4      = '{'{7, -3}, '{0, 9}};
        b4      = '{'{-2, 5}, '{4, 1}};
        zero_ab = '{'{0, 0}, '{0, 0}};
        c_zero  = '{'{0, 0}, '{0, 0}};

        // Reset state
        rst       = 1'b1;
        bus.start = 1'b0;
        set_ops(zero_ab, zero_ab);
        tick();
        tick();
        check_done("reset", 1'b0);
        check_c("reset", c_zero);
        rst = 1'b0;

        // Test 1: basic product, exact latency
        set_ops(a1, b1);
        bus.start = 1'b1;
        tick();                         // edge 0
        bus.start = 1'b0;
        check_done("t1_e0", 1'b0);
        tick();                         // edge 1
        check_done("t1_e1", 1'b0);
        tick();                         // edge 2
        check_done("t1_e2", 1'b1);
        check_c("t1", c1);
        tick();                         // edge 3
        check_done("t1_e3", 1'b0);
        check_c("t1_hold", c1);

        // Test 2: signed operands; start held into DONE is not queued
        set_ops(a2, b2);
        bus.start = 1'b1;
        tick();
        tick();
        tick();
        check_done("t2_e2", 1'b1);
        check_c("t2", c2);
        tick();
        check_done("t2_e3", 1'b0);
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check_done("t2_noqueue", 1'b0);
        check_c("t2_hold", c2);

        // Test 3: most-negative operands overflow the accumulator
        set_ops(a3, b3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check_done("t3_e2", 1'b1);
        check_c("t3", c3);
        tick();

        // Test 4: operand changes after the latch edge are ignored
        set_ops(a1, b1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        set_ops(zero_ab, zero_ab);
        tick();
        tick();
        check_done("t4_e2", 1'b1);
        check_c("t4", c1);
        tick();

        // Test 5: reset mid-job aborts; start right after release works
        set_ops(a1, b1);
        bus.start = 1'b1;
        tick();                         // edge 0
        bus.start = 1'b0;
        tick();                         // edge 1
        rst = 1'b1;
        #1;
        check_c("t5_async", c_zero);
        tick();                         // edge 2
        check_done("t5_abort", 1'b0);
        check_c("t5_abort", c_zero);
        rst = 1'b0;
        bus.start = 1'b1;
        tick();                         // latch
        bus.start = 1'b0;
        check_done("t5_r0", 1'b0);
        tick();
        check_done("t5_r1", 1'b0);
        tick();
        check_done("t5_r2", 1'b1);
        check_c("t5", c1);
        tick();
        check_done("t5_r3", 1'b0);

        // Test 6: start held high, back-to-back jobs with period K+2
        ops_a[0] = a1; ops_b[0] = b1;
        ops_a[1] = a2; ops_b[1] = b2;
        ops_a[2] = a4; ops_b[2] = b4;
        set_ops(ops_a[0], ops_b[0]);
        bus.start = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();                     // latch edge 4n
            model(ops_a[n], ops_b[n], exp_c);
            if (n < 2) begin
                set_ops(ops_a[n+1], ops_b[n+1]);
            end
            check_done($sformatf("t6_j%0d_e0", n), 1'b0);
            tick();
            check_done($sformatf("t6_j%0d_e1", n), 1'b0);
            tick();
            check_done($sformatf("t6_j%0d_e2", n), 1'b1);
            check_c($sformatf("t6_j%0d", n), exp_c);
            tick();
            check_done($sformatf("t6_j%0d_e3", n), 1'b0);
        end
        bus.start = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
